// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: PC width, PC word type and program-counter FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  localparam int PC_W = 9;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_t;

endpackage : fetch_pkg

// File: rtl/program_counter.sv
// Fetch-unit program counter: start loads an address, then +1 per cycle or absolute jump on taken branch.
// Latency: one cycle from input sample to pc_out; pc_out is a register with no combinational input path.
// Backpressure: none; sequencing never stalls and RUN is left only through reset.
module program_counter
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            branch,
  input  logic            taken,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_out
);

  pc_state_t state_q, state_d;
  pc_t       pc_q, pc_d;

  // Next-PC priority: start reloads from any state, IDLE holds, then taken branch, else increment.
  // The IDLE check sits ahead of the branch decode so branch/taken (even X) cannot touch pc while idle.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (start) begin
      pc_d    = start_addr;
      state_d = PC_RUN;
    end else if (state_q == PC_RUN) begin
      if (branch && taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_q + pc_t'(1);
      end
    end
  end

  // State and pc registers; synchronous active-low reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      state_q <= PC_IDLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc_out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: vector table plus hand-written idle/X sequence.
// Latency: expects each applied vector to appear on pc_out after the following rising edge.
// Backpressure: n/a.
module tb_program_counter;
  import fetch_pkg::*;

  typedef struct {
    string     name;
    logic      rst_n;
    logic      start;
    pc_t       start_addr;
    logic      branch;
    logic      taken;
    pc_t       target;
    pc_t       exp_pc;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  pc_t  start_addr;
  logic branch;
  logic taken;
  pc_t  target;
  pc_t  pc_out;

  int n_vec;
  int n_err;

  vec_t vecs[$];

  program_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .branch     (branch),
    .taken      (taken),
    .target     (target),
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string nm, input logic r, input logic s, input pc_t sa,
                     input logic b, input logic t, input pc_t tg, input pc_t e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = s; v.start_addr = sa;
    v.branch = b; v.taken = t; v.target = tg; v.exp_pc = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input pc_t exp_pc);
    n_vec++;
    if (pc_out !== exp_pc) begin
      n_err++;
      $display("FAIL %s: pc_out=0x%03h expected 0x%03h", nm, pc_out, exp_pc);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic s, input pc_t sa,
                      input logic b, input logic t, input pc_t tg);
    rst_n = r; start = s; start_addr = sa; branch = b; taken = t; target = tg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; branch = 1'b0; taken = 1'b0; target = '0;

    //   name             rst st  start_addr br tk target  expected
    add("reset0",         0, 0, 9'h000, 0, 0, 9'h000, 9'h000);
    add("reset1",         0, 0, 9'h000, 0, 0, 9'h000, 9'h000);
    add("idle_br0",       1, 0, 9'h000, 1, 1, 9'h0AA, 9'h000);
    add("idle_br1",       1, 0, 9'h000, 1, 1, 9'h0AA, 9'h000);
    add("idle_br2",       1, 0, 9'h000, 1, 1, 9'h0AA, 9'h000);
    add("start_010",      1, 1, 9'h010, 0, 0, 9'h000, 9'h010);
    add("seq_011",        1, 0, 9'h000, 0, 0, 9'h000, 9'h011);
    add("seq_012",        1, 0, 9'h000, 0, 0, 9'h000, 9'h012);
    add("seq_013",        1, 0, 9'h000, 0, 0, 9'h000, 9'h013);
    add("br_taken_100",   1, 0, 9'h000, 1, 1, 9'h100, 9'h100);
    add("after_br_101",   1, 0, 9'h000, 0, 0, 9'h000, 9'h101);
    add("br_not_taken",   1, 0, 9'h000, 1, 0, 9'h0AA, 9'h102);
    add("taken_no_br",    1, 0, 9'h000, 0, 1, 9'h0AA, 9'h103);
    add("seq_104",        1, 0, 9'h000, 0, 0, 9'h000, 9'h104);
    add("seq_105",        1, 0, 9'h000, 0, 0, 9'h000, 9'h105);
    add("midrun_reset",   0, 0, 9'h000, 0, 0, 9'h000, 9'h000);
    add("post_rst_hold0", 1, 0, 9'h000, 1, 1, 9'h0AA, 9'h000);
    add("post_rst_hold1", 1, 0, 9'h000, 0, 0, 9'h000, 9'h000);
    add("start_1fe",      1, 1, 9'h1FE, 0, 0, 9'h000, 9'h1FE);
    add("seq_1ff",        1, 0, 9'h000, 0, 0, 9'h000, 9'h1FF);
    add("wrap_000",       1, 0, 9'h000, 0, 0, 9'h000, 9'h000);
    add("wrap_001",       1, 0, 9'h000, 0, 0, 9'h000, 9'h001);
    add("start_vs_br",    1, 1, 9'h020, 1, 1, 9'h150, 9'h020);
    add("start_held1",    1, 1, 9'h020, 0, 0, 9'h000, 9'h020);
    add("start_held2",    1, 1, 9'h020, 0, 0, 9'h000, 9'h020);
    add("after_held_021", 1, 0, 9'h000, 0, 0, 9'h000, 9'h021);
    add("br_taken_150",   1, 0, 9'h000, 1, 1, 9'h150, 9'h150);
    add("rst_beats_start",0, 1, 9'h077, 1, 1, 9'h0AA, 9'h000);
    add("idle_after_rst", 1, 0, 9'h077, 0, 0, 9'h000, 9'h000);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].start, vecs[i].start_addr,
           vecs[i].branch, vecs[i].taken, vecs[i].target);
      check(vecs[i].name, vecs[i].exp_pc);
    end

    // Idle with unknown data inputs: pc must stay at 0, then a clean start must still load.
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000);
    check("x_seq_reset", 9'h000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 'x, 1'bx, 1'bx, 'x);
      check("x_idle_hold", 9'h000);
    end
    step(1'b1, 1'b1, 9'h0F0, 1'b0, 1'b0, 9'h000);
    check("x_seq_start", 9'h0F0);
    step(1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h033);
    check("x_seq_inc", 9'h0F1);

    // Long run: many increments then reset mid-run and confirm it stays parked.
    step(1'b1, 1'b1, 9'h1F0, 1'b0, 1'b0, 9'h000);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000);
      check("long_run", pc_t'(9'h1F0 + k));
    end
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000);
    check("long_run_rst", 9'h000);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000);
      check("long_run_park", 9'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_program_counter
